pwm_multichannel_gen: RTL

//  Parametrised N-channel PWM generator for the RGBW lamp datapath. It is the successor to the fixed 4x8-bit pwmGen.

---
 rtl/pwm_multichannel_gen_pkg.sv | 27 ++
 rtl/pwm_multichannel_gen_cmp.sv | 43 ++++
 rtl/pwm_multichannel_gen.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pwm_multichannel_gen_pkg.sv
// Purpose: shared RGBW lamp-datapath defaults and PWM helper functions.
// Latency: n/a (elaboration-time constants and functions only).
// Backpressure: n/a.
package pwm_multichannel_gen_pkg;

  // Defaults shared with colorGen and the data dispenser.
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_RES      = 8;
  localparam int DEF_PRESC_W  = 8;
  localparam int DEF_STAGGER  = 1;

  // Full-scale duty value; also the number of ticks in one PWM period.
  function automatic int pwm_max(input int res);
    return (1 << res) - 1;
  endfunction

  // Phase offset of channel idx: evenly spread over the period when
  // staggering, so LED turn-on edges do not all land on the same tick.
  function automatic int phase_offset(input int idx, input int res,
                                      input int channels, input int stagger);
    if (stagger != 0) begin
      return idx * (pwm_max(res) / channels);
    end
    return 0;
  endfunction

endpackage

// File: rtl/pwm_multichannel_gen_cmp.sv
// Purpose: one PWM channel - phase-shift the shared counter, compare against duty, register the pin.
// Latency: 1 clk from counter/duty to o_pwm.
// Backpressure: none; free-running output.
module pwm_channel_cmp
  import pwm_multichannel_gen_pkg::*;
#(
  parameter int RES    = DEF_RES,
  parameter int OFFSET = 0
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_en,
  input  logic [RES-1:0] i_cnt,
  input  logic [RES-1:0] i_duty,
  output logic           o_pwm
);

  localparam int           MAX   = pwm_max(RES);
  localparam logic [RES:0] L_MAX = (RES+1)'(MAX);
  localparam logic [RES:0] L_OFF = (RES+1)'(OFFSET);

  logic [RES:0] w_sum;
  logic [RES:0] w_ph;
  logic         w_on;
  logic         r_pwm;

  // One extra bit on the add so cnt+offset never overflows before the wrap.
  assign w_sum = {1'b0, i_cnt} + L_OFF;
  assign w_ph  = (w_sum >= L_MAX) ? (w_sum - L_MAX) : w_sum;
  assign w_on  = i_en && (w_ph < {1'b0, i_duty});

  // Registered pin so the lamp output is glitch-free.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= w_on;
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_multichannel_gen.sv
// Purpose: N-channel PWM generator with runtime prescaler, period-boundary duty double buffer, optional phase stagger.
// Latency: pwm_out lags the period counter by 1 clk; loaded duty takes effect at the next wrap (immediately while disabled).
// Backpressure: none; duty_ld is never refused, last load before a wrap wins, o_pending shows an unapplied load.
module pwm_multichannel_gen
  import pwm_multichannel_gen_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int RES      = DEF_RES,
  parameter int PRESC_W  = DEF_PRESC_W,
  parameter int STAGGER  = DEF_STAGGER
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_en,
  input  logic [PRESC_W-1:0]      i_presc,
  input  logic [CHANNELS*RES-1:0] i_duty_flat,
  input  logic                    i_duty_ld,
  output logic                    o_pending,
  output logic                    o_period_start,
  output logic [CHANNELS-1:0]     o_pwm_out
);

  localparam int             MAX      = pwm_max(RES);
  localparam logic [RES-1:0] CNT_LAST = RES'(MAX - 1);

  logic [PRESC_W-1:0]      r_presc_cnt;
  logic [RES-1:0]          r_cnt;
  logic [CHANNELS*RES-1:0] r_shadow;
  logic [CHANNELS*RES-1:0] r_active;
  logic                    r_pending;
  logic                    r_period_start;

  logic                    w_tick;
  logic                    w_wrap;
  logic [CHANNELS-1:0]     w_pwm;

  // ">=" rather than "==" so lowering presc below the running count
  // recovers on the very next clock instead of waiting for a rollover.
  assign w_tick = i_en && (r_presc_cnt >= i_presc);
  assign w_wrap = w_tick && (r_cnt == CNT_LAST);

  // Prescaler: counts clocks between ticks; held at 0 while disabled.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_presc_cnt <= '0;
    end else if (!i_en || w_tick) begin
      r_presc_cnt <= '0;
    end else begin
      r_presc_cnt <= r_presc_cnt + 1'b1;
    end
  end

  // Period counter: 0..MAX-1 advancing once per tick; held at 0 while disabled.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (!i_en || w_wrap) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Shadow duty register: captures every load strobe, last one wins.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_shadow <= '0;
    end else if (i_duty_ld) begin
      r_shadow <= i_duty_flat;
    end
  end

  // Active duty register: only changes at a period boundary so no channel
  // ever sees a truncated or doubled pulse; follows shadow while disabled.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_active <= '0;
    end else if (!i_en || w_wrap) begin
      r_active <= r_shadow;
    end
  end

  // Pending flag: set by a load, cleared when the shadow is applied. A load
  // landing on the wrap edge keeps it set because that data is not applied yet.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_pending <= 1'b0;
    end else if (!i_en) begin
      r_pending <= 1'b0;
    end else if (i_duty_ld) begin
      r_pending <= 1'b1;
    end else if (w_wrap) begin
      r_pending <= 1'b0;
    end
  end

  // Period-start pulse: one clock, registered from the wrap condition.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_period_start <= 1'b0;
    end else begin
      r_period_start <= w_wrap;
    end
  end

  // One comparator per channel, each with its own elaboration-time phase offset.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pwm_channel_cmp #(
      .RES    (RES),
      .OFFSET (phase_offset(g, RES, CHANNELS, STAGGER))
    ) u_cmp (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_en    (i_en),
      .i_cnt   (r_cnt),
      .i_duty  (r_active[g*RES +: RES]),
      .o_pwm   (w_pwm[g])
    );
  end

  assign o_pending      = r_pending;
  assign o_period_start = r_period_start;
  assign o_pwm_out      = w_pwm;

endmodule
